// File: rtl/ysyx_icache_pkg.sv
// Shared types and address-geometry helpers for the ysyx instruction cache.
package ysyx_icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } icache_state_t;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_SETS       = 16;

    function automatic int icache_word_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int icache_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int icache_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int icache_tag_w(input int addr_w, input int line_words, input int sets);
        return addr_w - icache_off_w(line_words) - icache_idx_w(sets);
    endfunction

endpackage

// File: rtl/ysyx_icache_if.sv
// Refill read channel between the icache (master) and the bus arbiter IFU port (slave).
interface ysyx_icache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output araddr, output arvalid, input rdata, input rvalid);
    modport slave  (input araddr, input arvalid, output rdata, output rvalid);
endinterface

// File: rtl/ysyx_icache_data_ram.sv
// Line data storage: one synchronous write port, one combinational read port.
module ysyx_icache_data_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache; misses refill a whole line word by word.
// Optional macro ICACHE_PERF_EN adds hit_cnt_o / miss_cnt_o performance counters.
module ysyx_icache
    import ysyx_icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int DATA_W     = ICACHE_DATA_W,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SETS       = ICACHE_SETS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                req_valid_i,
    output logic [DATA_W-1:0]   inst_o,
    output logic                resp_valid_o,
    input  logic                flush_i,
`ifdef ICACHE_PERF_EN
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o,
`endif
    ysyx_icache_if.master       bus
);
    localparam int WORD_W = icache_word_w(LINE_WORDS);
    localparam int OFF    = icache_off_w(LINE_WORDS);
    localparam int IDX_W  = icache_idx_w(SETS);
    localparam int TAG_W  = icache_tag_w(ADDR_W, LINE_WORDS, SETS);
    localparam int LINE_W = ADDR_W - OFF;
    localparam int RAM_AW = IDX_W + WORD_W;

    icache_state_t      state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  cnt_q, cnt_d;
    logic               alive_q, alive_d;
    logic               fpend_q, fpend_d;
    logic [DATA_W-1:0]  inst_q, inst_d;
    logic               hit_resp_q, hit_resp_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [SETS];
    logic               tag_we;

    logic [WORD_W-1:0]  pc_word;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;
    logic [1:0]         unused_pc;

    logic               ram_we;
    logic [RAM_AW-1:0]  ram_waddr;
    logic [RAM_AW-1:0]  ram_raddr;
    logic [DATA_W-1:0]  ram_rdata;

    assign pc_word   = pc_i[OFF-1:2];
    assign pc_idx    = pc_i[OFF+IDX_W-1:OFF];
    assign pc_tag    = pc_i[ADDR_W-1:OFF+IDX_W];
    assign unused_pc = pc_i[1:0];
    assign fill_idx  = line_q[IDX_W-1:0];
    assign fill_tag  = line_q[LINE_W-1:IDX_W];

    // A same-cycle flush wins over a hit, so the lookup falls through to a refill.
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !flush_i;

    assign ram_we    = (state_q == FILL) && bus.rvalid;
    assign ram_waddr = {fill_idx, cnt_q};
    assign ram_raddr = (state_q == IDLE) ? {pc_idx, pc_word} : {fill_idx, word_q};

    ysyx_icache_data_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (SETS * LINE_WORDS),
        .AW     (RAM_AW)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (bus.rdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_q     <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            alive_q    <= 1'b0;
            fpend_q    <= 1'b0;
            inst_q     <= '0;
            hit_resp_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            alive_q    <= alive_d;
            fpend_q    <= fpend_d;
            inst_q     <= inst_d;
            hit_resp_q <= hit_resp_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tag_q[fill_idx] <= fill_tag;
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        alive_d      = alive_q;
        fpend_d      = fpend_q;
        inst_d       = inst_q;
        hit_resp_d   = 1'b0;
        valid_d      = valid_q;
        tag_we       = 1'b0;
        bus.arvalid  = 1'b0;
        bus.araddr   = '0;
        resp_valid_o = hit_resp_q;
        inst_o       = inst_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (lookup_hit) begin
                        inst_d     = ram_rdata;
                        hit_resp_d = 1'b1;
                    end else begin
                        line_d  = pc_i[ADDR_W-1:OFF];
                        word_d  = pc_word;
                        cnt_d   = '0;
                        alive_d = 1'b1;
                        fpend_d = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                bus.arvalid = 1'b1;
                bus.araddr  = {line_q, cnt_q, 2'b00};
                if (!req_valid_i) alive_d = 1'b0;
                if (flush_i) fpend_d = 1'b1;
                if (bus.rvalid) begin
                    if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
                        tag_we = 1'b1;
                        // A flush seen at any point of the refill keeps the line invalid.
                        if (!fpend_q && !flush_i) valid_d[fill_idx] = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + WORD_W'(1);
                    end
                end
            end
            RESP: begin
                resp_valid_o = alive_q && req_valid_i;
                inst_o       = ram_rdata;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) valid_d = '0;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && req_valid_i) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && flush_i) $display("icache perf: hits=%0d misses=%0d", hit_cnt_q, miss_cnt_q);
    end
`endif
`endif

`ifndef SYNTHESIS
    // The fetch address may only move once the pending request has been answered or withdrawn.
    pc_stable_a: assert property (@(posedge clk) disable iff (!rst)
        (req_valid_i && $past(req_valid_i) && !resp_valid_o) |-> (pc_i == $past(pc_i)));
`endif

endmodule

// File: tb/tb_ysyx_icache.sv
// Randomized self-checking bench for ysyx_icache against a line-level reference model.
module tb_ysyx_icache;
    localparam int LINE_WORDS = 4;
    localparam int SETS       = 16;

    logic        clk = 1'b0;
    logic        rst_r;
    logic [31:0] pc_r;
    logic        req_r;
    logic        flush_r;
    logic [31:0] inst_w;
    logic        resp_w;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_w, miss_cnt_w;
`endif

    ysyx_icache_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ysyx_icache #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LINE_WORDS), .SETS(SETS)) dut (
        .clk          (clk),
        .rst          (rst_r),
        .pc_i         (pc_r),
        .req_valid_i  (req_r),
        .inst_o       (inst_w),
        .resp_valid_o (resp_w),
        .flush_i      (flush_r),
`ifdef ICACHE_PERF_EN
        .hit_cnt_o    (hit_cnt_w),
        .miss_cnt_o   (miss_cnt_w),
`endif
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which memory line each set holds, and whether it is valid.
    bit          m_valid [SETS];
    logic [27:0] m_line  [SETS];

    int          bus_lat = 1;
    int          arv_cycles = 0;
    int          wait_cnt = 0;
    logic [31:0] addr_log [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endtask

    // Arbiter side: each word takes bus_lat idle cycles then one rvalid cycle;
    // stray rvalid pulses are thrown in while no read is outstanding.
    always begin
        @(posedge clk);
        #1;
        if (!rst_r || !bus_if.arvalid) begin
            wait_cnt = 0;
            if (rst_r && $urandom_range(0, 3) == 0) begin
                bus_if.rvalid = 1'b1;
                bus_if.rdata  = $urandom;
            end else begin
                bus_if.rvalid = 1'b0;
            end
        end else begin
            arv_cycles++;
            if (wait_cnt >= bus_lat) begin
                bus_if.rvalid = 1'b1;
                bus_if.rdata  = mem_rd(bus_if.araddr);
                addr_log.push_back(bus_if.araddr);
                wait_cnt = 0;
            end else begin
                bus_if.rvalid = 1'b0;
                wait_cnt++;
            end
        end
    end

    task automatic idle_flush();
        @(negedge clk);
        flush_r = 1'b1;
        @(negedge clk);
        flush_r = 1'b0;
        model_flush();
    endtask

    // One fetch; flush_beat/drop_beat >= 0 inject a flush / redirect once that many words arrived.
    task automatic fetch(input logic [31:0] pc, input bit same_flush, input int flush_beat, input int drop_beat);
        bit          exp_hit, got, flushed, dropped;
        int          cyc, got_cyc, base_n, arv0, settle, nb, idx, exp_lat;
        logic [31:0] got_inst, line_base;
        idx       = int'(pc[7:4]);
        line_base = {pc[31:4], 4'h0};
        exp_hit   = !same_flush && m_valid[idx] && (m_line[idx] == pc[31:4]);
        exp_lat   = exp_hit ? 1 : LINE_WORDS * (bus_lat + 1) + 1;
        got = 0; flushed = 0; dropped = 0; cyc = 0; got_cyc = 0; settle = 0; got_inst = '0;
        @(negedge clk);
        base_n  = addr_log.size();
        arv0    = arv_cycles;
        pc_r    = pc;
        req_r   = 1'b1;
        flush_r = same_flush;
        if (same_flush) model_flush();
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            flush_r = 1'b0;
            nb = addr_log.size() - base_n;
            if (resp_w) begin
                got = 1; got_cyc = cyc; got_inst = inst_w;
                break;
            end
            if (dropped && nb == LINE_WORDS) begin
                settle++;
                if (settle == 3) break;
            end
            if (!exp_hit && flush_beat >= 0 && !flushed && nb >= flush_beat) begin
                flush_r = 1'b1; flushed = 1;
            end
            if (!exp_hit && drop_beat >= 0 && !dropped && nb >= drop_beat) begin
                req_r = 1'b0; dropped = 1;
            end
        end
        nb = addr_log.size() - base_n;
        if (dropped) begin
            check_eq("redirect_quiet", 32'(got), 32'd0);
        end else begin
            check_eq("resp_seen", 32'(got), 32'd1);
            check_eq("inst", got_inst, mem_rd(pc));
            check_eq("latency", got_cyc, exp_lat);
        end
        check_eq("arvalid_cycles", arv_cycles - arv0, exp_hit ? 0 : LINE_WORDS * (bus_lat + 1));
        check_eq("beats", nb, exp_hit ? 0 : LINE_WORDS);
        for (int k = 0; k < nb && k < LINE_WORDS; k++)
            check_eq("araddr", addr_log[base_n + k], line_base + 32'(4 * k));
        req_r   = 1'b0;
        flush_r = 1'b0;
        @(negedge clk);
        check_eq("resp_pulse", 32'(resp_w), 32'd0);
        if (flushed) model_flush();
        if (!exp_hit) begin
            m_line[idx]  = pc[31:4];
            m_valid[idx] = !flushed;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          fb, db, nb, base_n;
        bit          sf;
        rst_r = 1'b0; req_r = 1'b0; flush_r = 1'b0; pc_r = '0;
        model_flush();
        repeat (3) @(negedge clk);
        check_eq("rst_resp", 32'(resp_w), 32'd0);
        check_eq("rst_inst", inst_w, 32'd0);
        check_eq("rst_arvalid", 32'(bus_if.arvalid), 32'd0);
        check_eq("rst_araddr", bus_if.araddr, 32'd0);
        rst_r = 1'b1;
        repeat (2) @(negedge clk);

        bus_lat = 1;
        fetch(32'h8000_0008, 0, -1, -1);
        fetch(32'h8000_000C, 0, -1, -1);

        @(negedge clk);
        pc_r = 32'h8000_0000; req_r = 1'b1;
        @(negedge clk);
        check_eq("b2b_valid0", 32'(resp_w), 32'd1);
        check_eq("b2b_inst0", inst_w, 32'h11);
        pc_r = 32'h8000_0004;
        @(negedge clk);
        check_eq("b2b_valid1", 32'(resp_w), 32'd1);
        check_eq("b2b_inst1", inst_w, 32'h22);
        req_r = 1'b0;
        @(negedge clk);
        check_eq("b2b_end", 32'(resp_w), 32'd0);

        fetch(32'h8000_0100, 0, -1, -1);
        fetch(32'h8000_0000, 0, -1, -1);
        idle_flush();
        fetch(32'h8000_0004, 0, -1, -1);
        fetch(32'h8000_0020, 0, 2, -1);
        fetch(32'h8000_0020, 0, -1, -1);
        fetch(32'h8000_0000, 1, -1, -1);
        fetch(32'h8000_0100, 0, -1, -1);
        fetch(32'h8000_0000, 0, -1, 2);
        fetch(32'h8000_0000, 0, -1, -1);

        bus_lat = 1;
        @(negedge clk);
        base_n = addr_log.size();
        pc_r = 32'h8000_0300; req_r = 1'b1;
        nb = 0;
        for (int c = 0; c < 100 && nb < 3; c++) begin
            @(negedge clk);
            nb = addr_log.size() - base_n;
        end
        check_eq("rst_fill_reached", 32'(nb >= 3), 32'd1);
        rst_r = 1'b0;
        #1;
        check_eq("rst_mid_arvalid", 32'(bus_if.arvalid), 32'd0);
        check_eq("rst_mid_resp", 32'(resp_w), 32'd0);
        req_r = 1'b0;
        model_flush();
        repeat (2) @(negedge clk);
        rst_r = 1'b1;
        fetch(32'h8000_0000, 0, -1, -1);

        for (int i = 0; i < 300; i++) begin
            pc = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8) |
                 (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
            bus_lat = int'($urandom_range(0, 2));
            sf = ($urandom_range(0, 15) == 0);
            fb = -1;
            db = -1;
            if ($urandom_range(0, 7) == 0) fb = int'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) db = int'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) idle_flush();
            fetch(pc, sf, fb, db);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_icache.md
Name: ysyx_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU and the bus arbiter's IFU read port.
- Serves hits from local arrays with one cycle of latency.
- On a miss, refills one line as LINE_WORDS sequential single-word reads through the arbiter's ifu_araddr/ifu_arvalid/ifu_rdata/ifu_rvalid channel, then returns the requested word.
- Supports whole-cache invalidation (fence.i).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction/word width.
- LINE_WORDS, 4, words per line; power of two, at least 2.
- SETS, 16, number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pc_i  in  ADDR_W  fetch address, word aligned; held stable while req_valid_i is high.
- req_valid_i  in  1  fetch request; level, held until resp_valid_o or IFU redirect.
- inst_o  out  DATA_W  fetched word; valid only when resp_valid_o is high.
- resp_valid_o  out  1  one-cycle pulse, inst_o valid.
- flush_i  in  1  one-cycle pulse, invalidate all lines.
- bus_araddr_o  out  ADDR_W  to arbiter ifu_araddr.
- bus_arvalid_o  out  1  to arbiter ifu_arvalid; level-held until bus_rvalid_i.
- bus_rdata_i  in  DATA_W  from arbiter ifu_rdata_o.
- bus_rvalid_i  in  1  from arbiter ifu_rvalid_o.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2 bits; word index = pc[OFF-1:2].
  - IDX = log2(SETS) bits at pc[OFF+IDX-1:OFF].
  - TAG = pc[ADDR_W-1:OFF+IDX].
- Reset (rst low, asynchronous):
  - state IDLE; all valid bits 0; fill counter 0.
  - resp_valid_o 0, bus_arvalid_o 0, bus_araddr_o 0, inst_o 0.
  - Data/tag arrays are not reset.
- States: IDLE, FILL, RESP.
- IDLE:
  - req_valid_i high and hit (valid[idx] and tag match): register the word; resp_valid_o = 1 next cycle; stay IDLE. Back-to-back hits give one response per cycle.
  - req_valid_i high and miss: latch line base (pc with OFF bits zeroed) and requested word index; k = 0; go to FILL.
- FILL:
  - bus_arvalid_o = 1; bus_araddr_o = base + 4*k.
  - On bus_rvalid_i: write bus_rdata_i to data[idx][k].
    - If k == LINE_WORDS-1: write tag; set valid[idx] unless a flush arrived during this fill; go to RESP.
    - Otherwise k increments and the address updates next cycle; bus_arvalid_o stays high continuously.
  - bus_rvalid_i while bus_arvalid_o is low is ignored.
- RESP:
  - resp_valid_o = 1 for exactly one cycle.
  - inst_o = data[idx][requested word], taken from the filled line.
  - Go to IDLE.
  - Suppressed if req_valid_i dropped during the fill (redirect). The line is still installed.
- Miss latency: LINE_WORDS bus round trips plus 1 cycle. Hit latency: 1 cycle.
- flush_i:
  - Clears all valid bits in the cycle it is sampled.
  - Takes priority over a same-cycle hit: that lookup is treated as a miss.
  - During FILL: the fill completes and the response is delivered, but valid is not set for that line.
- pc_i must not change while req_valid_i is high before the response; behaviour otherwise is undefined and is an assertion failure in simulation.
- Reset mid-fill: bus_arvalid_o drops immediately and asynchronously; partial line data is discarded (valid stays 0).
- A fill overwrites the previous line at the same index: tag replaced, valid rewritten.

Optional Feature:
- ICACHE_PERF_EN defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], reset to 0, wrapping at 2^32.
  - hit_cnt increments on each IDLE hit; miss_cnt increments on each IDLE→FILL.
  - $display of the counters when flush_i is asserted.
- Not defined: the ports and counters are absent; no other behavioural change.

Decomposition:
- Package ysyx_icache_pkg:
  - state enum icache_state_t {IDLE, FILL, RESP}.
  - localparam helpers for OFF/IDX/TAG widths from LINE_WORDS/SETS/ADDR_W.
- One sub-module, ysyx_icache_data_ram:
  - SETS*LINE_WORDS x DATA_W.
  - One synchronous write port, one combinational read port.
- Tag/valid storage stays in the top level.

Test Plan:
- Cold miss: req pc=0x80000008, bus returns 0x11,0x22,0x33,0x44 for 0x80000000..0x8000000C, one word per 2 cycles → bus_araddr_o sequence 0x80000000,04,08,0C; inst_o=0x33 with resp_valid_o for one cycle; total latency 9 cycles.
- Hit after fill: req pc=0x8000000C → resp_valid_o next cycle with inst_o=0x44; bus_arvalid_o stays 0.
- Conflict: fill 0x80000000, then req 0x80000100 (same index, different tag) → refill; re-request of 0x80000000 misses again.
- Flush: flush_i pulse after fill, then req 0x80000004 → miss and refill. flush_i during FILL → response delivered, next same-line request misses.
- Redirect: drop req_valid_i after 2nd rvalid → no resp_valid_o; line installed; later req 0x80000000 hits.
- Reset mid-fill: assert rst low during 3rd bus word → bus_arvalid_o 0 same cycle; after release, req 0x80000000 misses.
